// File: rtl/neuron_accum.sv
// neuron_accum: accumulates a counted burst of unsigned products, then emits a shifted, saturated activation.
module neuron_accum #(
    parameter int ACC_W = 16,
    parameter int SHIFT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] num_inputs,
    input  logic [7:0] prod_in,
    input  logic       prod_valid,
    output logic       prod_ready,
    output logic [7:0] act_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, ACTIVATE, HOLD} state_t;
    state_t state, state_nx;
    logic [ACC_W-1:0] acc, shifted;
    logic [3:0] remaining;
    logic accept;
    assign prod_ready = state == ACCUM;
    assign out_valid  = state == HOLD;
    assign busy       = state != IDLE;
    assign accept     = prod_ready && prod_valid;
    assign shifted    = acc >> SHIFT;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = start ? ((num_inputs != 4'd0) ? ACCUM : ACTIVATE) : IDLE;
            ACCUM:    state_nx = (accept && remaining == 4'd1) ? ACTIVATE : ACCUM;
            ACTIVATE: state_nx = HOLD;
            HOLD:     state_nx = out_ready ? IDLE : HOLD;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            remaining <= '0;
            act_out   <= '0;
        end else begin
            if (state == IDLE && start) begin
                acc       <= '0;
                remaining <= num_inputs;
            end
            if (accept) begin
                acc       <= acc + ACC_W'(prod_in);
                remaining <= remaining - 4'd1;
            end
            // Saturate anything above 8 bits after the shift.
            if (state == ACTIVATE)
                act_out <= (shifted > ACC_W'(255)) ? 8'hff : shifted[7:0];
        end
    end
endmodule
